// File: rtl/bytebeat_sample_scheduler.sv
// bytebeat_sample_scheduler
//   Frame-rate scheduler that time-shares one 16-bit control bus between
//   NUM_VOICES bytebeat cores. On each frame tick it visits every voice in
//   order. For each voice it pushes the control word over the voice's
//   parameter channel, then pulls one PCM byte from the voice's output
//   channel. The collected bytes are committed to `samples` in one step.
//   A handshake that waits TIMEOUT cycles is abandoned: the voice is
//   marked stale and err_cnt is incremented.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   knobs[15:0]           control word, captured on the frame tick
//   par_data/par_vld      control word broadcast + one-hot valid to served voice
//   par_rdy               per-voice parameter ready
//   pcm_in/pcm_vld        per-voice output byte ([8i+7:8i]) + valid
//   pcm_rdy               one-hot output ready to served voice
//   samples               committed bytes, held between commits
//   sample_stb            one-cycle pulse when new samples become visible
//   stale                 per-voice timeout flag of the last committed frame
//   overrun               sticky, set by a tick arriving mid-frame
//   err_cnt               saturating handshake-timeout count
//
// Optional feature macro: SCHED_VOICE_MASK_EN
//   When this macro is defined, the module has a voice_en input, which is
//   sampled on the tick. Disabled voices are skipped in zero cycles. Their
//   committed sample is 8'h80 and their stale bit is 0.

module bytebeat_sample_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int DIV        = 512,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               knobs,
`ifdef SCHED_VOICE_MASK_EN
  input  logic [NUM_VOICES-1:0]     voice_en,
`endif
  output logic [15:0]               par_data,
  output logic [NUM_VOICES-1:0]     par_vld,
  input  logic [NUM_VOICES-1:0]     par_rdy,
  input  logic [8*NUM_VOICES-1:0]   pcm_in,
  input  logic [NUM_VOICES-1:0]     pcm_vld,
  output logic [NUM_VOICES-1:0]     pcm_rdy,
  output logic [8*NUM_VOICES-1:0]   samples,
  output logic                      sample_stb,
  output logic [NUM_VOICES-1:0]     stale,
  output logic                      overrun,
  output logic [7:0]                err_cnt
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int FW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, PARAM, COLLECT, COMMIT} state_t;

  state_t                   state, state_n;
  logic [FW-1:0]            fcnt;
  logic [VW-1:0]            v, v_n;
  logic [7:0]               wcnt;
  logic [8*NUM_VOICES-1:0]  shadow;
  logic [NUM_VOICES-1:0]    sh_stale;
  logic [NUM_VOICES-1:0]    en_start;   // enable mask seen at the tick
  logic [NUM_VOICES-1:0]    en_cur;     // enable mask of the frame in progress
  logic                     tick, wto, cap, miss;
  logic                     first_ok, nxt_ok;
  logic [VW-1:0]            first_v, nxt_v;

`ifdef SCHED_VOICE_MASK_EN
  logic [NUM_VOICES-1:0]    en_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_r <= '1;
    end else if (state == IDLE && tick) begin
      en_r <= voice_en;
    end
  end

  assign en_start = voice_en;
  assign en_cur   = en_r;
`else
  assign en_start = '1;
  assign en_cur   = '1;
`endif

  assign tick = (fcnt == FW'(DIV - 1));
  assign wto  = (wcnt == 8'(TIMEOUT - 1));

  always_comb begin
    first_ok = 1'b0;
    first_v  = '0;
    nxt_ok   = 1'b0;
    nxt_v    = '0;
    // Find the first enabled voice, and the next enabled voice after v.
    // Disabled voices therefore use no cycles.
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!first_ok && en_start[i]) begin
        first_ok = 1'b1;
        first_v  = VW'(i);
      end
      if (!nxt_ok && en_cur[i] && (VW'(i) > v)) begin
        nxt_ok = 1'b1;
        nxt_v  = VW'(i);
      end
    end

    state_n = state;
    v_n     = v;
    cap     = 1'b0;
    miss    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          v_n     = first_v;
          state_n = first_ok ? PARAM : COMMIT;
        end
      end
      PARAM: begin
        if (par_rdy[v]) begin
          state_n = COLLECT;
        end else if (wto) begin
          miss = 1'b1;
        end
      end
      COLLECT: begin
        if (pcm_vld[v]) begin
          cap = 1'b1;
        end else if (wto) begin
          miss = 1'b1;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A successful collect and a timeout advance the same way. A PARAM
    // timeout therefore skips that voice's COLLECT.
    if (cap || miss) begin
      if (nxt_ok) begin
        state_n = PARAM;
        v_n     = nxt_v;
      end else begin
        state_n = COMMIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fcnt       <= '0;
      v          <= '0;
      wcnt       <= '0;
      par_data   <= '0;
      par_vld    <= '0;
      pcm_rdy    <= '0;
      shadow     <= {NUM_VOICES{8'h80}};
      sh_stale   <= '0;
      samples    <= {NUM_VOICES{8'h80}};
      stale      <= '0;
      sample_stb <= 1'b0;
      overrun    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      fcnt  <= tick ? '0 : fcnt + 1'b1;
      state <= state_n;
      v     <= v_n;

      // The wait counter restarts on every change of state or voice.
      if (state_n != state || v_n != v) begin
        wcnt <= '0;
      end else if (wcnt != 8'hFF) begin
        wcnt <= wcnt + 8'd1;
      end

      // The handshake strobes are driven from the next state, so they are
      // registered and still valid in the first cycle of each phase.
      par_vld <= (state_n == PARAM)   ? (NUM_VOICES'(1) << v_n) : '0;
      pcm_rdy <= (state_n == COLLECT) ? (NUM_VOICES'(1) << v_n) : '0;

      if (state == IDLE && tick) begin
        par_data <= knobs;
        sh_stale <= '0;
      end

      if (cap) begin
        shadow[8*v +: 8] <= pcm_in[8*v +: 8];
      end

      if (miss) begin
        sh_stale[v] <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end

      sample_stb <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          samples[8*i +: 8] <= en_cur[i] ? shadow[8*i +: 8] : 8'h80;
        end
        stale <= sh_stale & en_cur;
      end

      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bytebeat_sample_scheduler.sv
module tb_bytebeat_sample_scheduler;

  localparam int N   = 8;
  localparam int DIV = 512;
  localparam int TO  = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [15:0]    knobs;
  logic [15:0]    par_data;
  logic [N-1:0]   par_vld;
  logic [N-1:0]   par_rdy;
  logic [8*N-1:0] pcm_in;
  logic [N-1:0]   pcm_vld;
  logic [N-1:0]   pcm_rdy;
  logic [8*N-1:0] samples;
  logic           sample_stb;
  logic [N-1:0]   stale;
  logic           overrun;
  logic [7:0]     err_cnt;
  logic [N-1:0]   cur_en;
`ifdef SCHED_VOICE_MASK_EN
  logic [N-1:0]   voice_en;
`endif

  bytebeat_sample_scheduler #(
    .NUM_VOICES (N),
    .DIV        (DIV),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .knobs      (knobs),
`ifdef SCHED_VOICE_MASK_EN
    .voice_en   (voice_en),
`endif
    .par_data   (par_data),
    .par_vld    (par_vld),
    .par_rdy    (par_rdy),
    .pcm_in     (pcm_in),
    .pcm_vld    (pcm_vld),
    .pcm_rdy    (pcm_rdy),
    .samples    (samples),
    .sample_stb (sample_stb),
    .stale      (stale),
    .overrun    (overrun),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the frame counter value.
  int tb_cyc;
  always @(posedge clk) begin
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [8*N-1:0] samp;
    logic [N-1:0]   stl;
    logic [7:0]     err;
    int             lat;
    logic [15:0]    pd;
    logic [N-1:0]   first_vld;
  } exp_t;

  exp_t           sb[$];
  exp_t           me;
  logic [8*N-1:0] m_shadow;
  logic [7:0]     m_err;

  // Predicts the frame outcome for the static handshake inputs currently
  // driven, and pushes the result to the scoreboard.
  task automatic predict_frame(output exp_t e);
    bit found;
    found       = 1'b0;
    e.lat       = 2;
    e.stl       = '0;
    e.first_vld = '0;
    e.pd        = knobs;
    for (int i = 0; i < N; i++) begin
      if (!cur_en[i]) begin
        e.samp[8*i +: 8] = 8'h80;
      end else begin
        if (!found) begin
          e.first_vld[i] = 1'b1;
          found = 1'b1;
        end
        if (!par_rdy[i]) begin
          e.lat += TO;
          e.stl[i] = 1'b1;
          if (m_err != 8'hFF) m_err++;
        end else if (!pcm_vld[i]) begin
          e.lat += 1 + TO;
          e.stl[i] = 1'b1;
          if (m_err != 8'hFF) m_err++;
        end else begin
          e.lat += 2;
          m_shadow[8*i +: 8] = pcm_in[8*i +: 8];
        end
        e.samp[8*i +: 8] = m_shadow[8*i +: 8];
      end
    end
    e.err = m_err;
    sb.push_back(e);
  endtask

  // Output side of the scoreboard: each strobe pops one expected frame.
  always @(negedge clk) begin
    if (!reset && sample_stb) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stb_unexpected: sample_stb=1 at cycle %0d, required 0", tb_cyc);
      end else begin
        me = sb.pop_front();
        n_checks += 2;
        if (samples !== me.samp) begin
          n_fail++;
          $display("FAIL samples: got %h, required %h", samples, me.samp);
        end
        if (stale !== me.stl) begin
          n_fail++;
          $display("FAIL stale: got %h, required %h", stale, me.stl);
        end
        if (err_cnt !== me.err) begin
          n_fail++;
          $display("FAIL err_cnt: got %0d, required %0d", err_cnt, me.err);
        end
      end
    end
  end

  // Waits for the next tick, then for the strobe. Both waits are bounded.
  task automatic run_frame(output int t, output int s, output bit got,
                           output logic [N-1:0] vld1, output logic [15:0] pd1,
                           output logic [N-1:0] vld_or, output int early,
                           output logic stb2);
    t = -1; s = -1; got = 1'b0; early = 0;
    vld1 = '0; pd1 = '0; vld_or = '0; stb2 = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (sample_stb) early++;
      if (tb_cyc % DIV == DIV - 1) begin
        t = tb_cyc;
        break;
      end
    end
    if (t >= 0) begin
      @(negedge clk);
      vld1   = par_vld;
      pd1    = par_data;
      vld_or = par_vld;
      for (int k = 0; k < 700; k++) begin
        @(negedge clk);
        vld_or |= par_vld;
        if (sample_stb) begin
          s   = tb_cyc;
          got = 1'b1;
          break;
        end
      end
      if (got) begin
        @(negedge clk);
        stb2 = sample_stb;
      end
    end
  endtask

  task automatic set_pcm(input logic [7:0] base);
    for (int i = 0; i < N; i++) pcm_in[8*i +: 8] = base + 8'(i);
  endtask

  task automatic test_reset();
    reset = 1'b1; knobs = '0; par_rdy = '0; pcm_vld = '0; pcm_in = '0;
    cur_en = '1;
`ifdef SCHED_VOICE_MASK_EN
    voice_en = '1;
`endif
    m_shadow = {N{8'h80}}; m_err = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks += 6;
    if (samples !== {N{8'h80}}) begin n_fail++; $display("FAIL rst_samples: got %h, required %h", samples, {N{8'h80}}); end
    if (stale !== '0)   begin n_fail++; $display("FAIL rst_stale: got %h, required 0", stale); end
    if (err_cnt !== '0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d, required 0", err_cnt); end
    if (overrun !== 1'b0 || sample_stb !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags: overrun=%b stb=%b, required 0 0", overrun, sample_stb);
    end
    if (par_vld !== '0 || pcm_rdy !== '0) begin
      n_fail++; $display("FAIL rst_hs: par_vld=%h pcm_rdy=%h, required 0 0", par_vld, pcm_rdy);
    end
    if (par_data !== '0) begin n_fail++; $display("FAIL rst_par_data: got %h, required 0", par_data); end
  endtask

  task automatic test_all_ready();
    exp_t e; int t, s, early; bit got; logic [N-1:0] vld1, vld_or; logic [15:0] pd1; logic stb2;
    knobs = 16'hA5C3; par_rdy = '1; pcm_vld = '1; set_pcm(8'h10);
    predict_frame(e);
    run_frame(t, s, got, vld1, pd1, vld_or, early, stb2);
    n_checks += 5;
    if (t !== DIV - 1) begin n_fail++; $display("FAIL first_tick: got cycle %0d, required %0d", t, DIV - 1); end
    if (vld1 !== 8'h01) begin n_fail++; $display("FAIL first_par_vld: got %h, required 01", vld1); end
    if (pd1 !== 16'hA5C3) begin n_fail++; $display("FAIL par_data: got %h, required a5c3", pd1); end
    if (!got || s - t !== e.lat) begin n_fail++; $display("FAIL latency_all_ready: got %0d (seen=%0d), required %0d", s - t, got, e.lat); end
    if (stb2 !== 1'b0) begin n_fail++; $display("FAIL stb_width: got %b one cycle later, required 0", stb2); end
  endtask

  task automatic test_par_timeout();
    exp_t e; int t, s, early; bit got; logic [N-1:0] vld1, vld_or; logic [15:0] pd1; logic stb2;
    par_rdy = 8'hF7; pcm_vld = '1; set_pcm(8'h20);
    predict_frame(e);
    run_frame(t, s, got, vld1, pd1, vld_or, early, stb2);
    n_checks += 2;
    if (!got || s - t !== e.lat) begin n_fail++; $display("FAIL latency_par_timeout: got %0d (seen=%0d), required %0d", s - t, got, e.lat); end
    if (vld_or !== 8'hFF) begin n_fail++; $display("FAIL par_vld_cover: got %h, required ff", vld_or); end
  endtask

  task automatic test_pcm_timeout();
    exp_t e; int t, s, early; bit got; logic [N-1:0] vld1, vld_or; logic [15:0] pd1; logic stb2;
    par_rdy = '1; pcm_vld = 8'hDF; set_pcm(8'h30);
    predict_frame(e);
    run_frame(t, s, got, vld1, pd1, vld_or, early, stb2);
    n_checks += 1;
    if (!got || s - t !== e.lat) begin n_fail++; $display("FAIL latency_pcm_timeout: got %0d (seen=%0d), required %0d", s - t, got, e.lat); end
  endtask

  task automatic test_overrun();
    exp_t e; int t, s, early; bit got; logic [N-1:0] vld1, vld_or; logic [15:0] pd1; logic stb2;
    n_checks += 1;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b, required 0", overrun); end
    par_rdy = '0; pcm_vld = '1; set_pcm(8'h38);
    predict_frame(e);
    run_frame(t, s, got, vld1, pd1, vld_or, early, stb2);
    n_checks += 2;
    if (!got || s - t !== e.lat) begin n_fail++; $display("FAIL latency_overrun: got %0d (seen=%0d), required %0d", s - t, got, e.lat); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, required 1", overrun); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int t, s, early; bit got; logic [N-1:0] vld1, vld_or; logic [15:0] pd1; logic stb2;
    knobs = 16'h1234; par_rdy = '1; pcm_vld = '1; set_pcm(8'h40);
    predict_frame(e);
    run_frame(t, s, got, vld1, pd1, vld_or, early, stb2);
    n_checks += 4;
    if (early !== 0) begin n_fail++; $display("FAIL dropped_tick: got %0d extra strobes, required 0", early); end
    if (!got || s - t !== e.lat) begin n_fail++; $display("FAIL latency_b2b: got %0d (seen=%0d), required %0d", s - t, got, e.lat); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
    if (pd1 !== 16'h1234) begin n_fail++; $display("FAIL par_data_b2b: got %h, required 1234", pd1); end
  endtask

  task automatic test_reset_midframe();
    int t; int nstb;
    t = -1; nstb = 0;
    pcm_vld = 8'hEF;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (tb_cyc % DIV == DIV - 1) begin t = tb_cyc; break; end
    end
    repeat (20) @(negedge clk);
    n_checks += 1;
    if (t < 0 || pcm_rdy !== 8'h10 || par_vld !== '0) begin
      n_fail++; $display("FAIL collect_v4: tick=%0d pcm_rdy=%h par_vld=%h, required tick seen, 10, 00", t, pcm_rdy, par_vld);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_shadow = {N{8'h80}}; m_err = '0;
    n_checks += 4;
    if (samples !== {N{8'h80}} || stale !== '0) begin
      n_fail++; $display("FAIL midrst_samples: samples=%h stale=%h, required all 80, 0", samples, stale);
    end
    if (err_cnt !== '0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL midrst_counters: err_cnt=%0d overrun=%b, required 0 0", err_cnt, overrun);
    end
    if (par_vld !== '0 || pcm_rdy !== '0 || par_data !== '0) begin
      n_fail++; $display("FAIL midrst_hs: par_vld=%h pcm_rdy=%h par_data=%h, required 0", par_vld, pcm_rdy, par_data);
    end
    if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL midrst_stb: got %b, required 0", sample_stb); end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sample_stb) nstb++;
    end
    n_checks += 1;
    if (nstb !== 0 || sb.size() !== 0) begin
      n_fail++; $display("FAIL midrst_commit: got %0d strobes, queue %0d, required 0 0", nstb, sb.size());
    end
  endtask

  task automatic test_after_reset();
    exp_t e; int t, s, early; bit got; logic [N-1:0] vld1, vld_or; logic [15:0] pd1; logic stb2;
    knobs = 16'h5A5A; pcm_vld = '1; par_rdy = '1; set_pcm(8'h50);
    predict_frame(e);
    run_frame(t, s, got, vld1, pd1, vld_or, early, stb2);
    n_checks += 2;
    if (t !== DIV - 1) begin n_fail++; $display("FAIL tick_after_reset: got cycle %0d, required %0d", t, DIV - 1); end
    if (!got || s - t !== e.lat) begin n_fail++; $display("FAIL latency_after_reset: got %0d (seen=%0d), required %0d", s - t, got, e.lat); end
  endtask

`ifdef SCHED_VOICE_MASK_EN
  task automatic test_mask();
    exp_t e; int t, s, early; bit got; logic [N-1:0] vld1, vld_or; logic [15:0] pd1; logic stb2;
    cur_en = 8'hAA; voice_en = 8'hAA; set_pcm(8'h60);
    predict_frame(e);
    run_frame(t, s, got, vld1, pd1, vld_or, early, stb2);
    n_checks += 3;
    if (vld_or !== 8'hAA) begin n_fail++; $display("FAIL mask_par_vld: got %h, required aa", vld_or); end
    if (vld1 !== e.first_vld) begin n_fail++; $display("FAIL mask_first_vld: got %h, required %h", vld1, e.first_vld); end
    if (!got || s - t !== e.lat) begin n_fail++; $display("FAIL latency_mask: got %0d (seen=%0d), required %0d", s - t, got, e.lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ready();
    test_par_timeout();
    test_pcm_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_after_reset();
`ifdef SCHED_VOICE_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
